// File: rtl/mca_s_window_buffer.sv
// mca_s_window_buffer
//
// Front end of the FIR estimator. It collects one N-bit control-signal vector
// per accepted sample into a K-deep lookback register. Every DSR-th accepted
// sample it freezes that register into a held window and pulses start. The
// window then stays stable while the downstream multi-cycle adder works on it.
//
// Handshake: s_valid has no ready. Every rising edge with s_valid high
// accepts s_in. The block never stalls the source.
//
// Ports
//   clk          single clock, rising edge
//   resetn       synchronous, active-low reset
//   s_in         control-signal vector of the current sample
//   s_valid      s_in is accepted on this edge
//   overrun_clr  clears the sticky overrun flag (a drop on the same edge wins)
//   S_matrix     held window; [0] is the newest sample, [K-1] the oldest
//   start        one-cycle pulse; S_matrix was refreshed on the same edge
//   primed       K or more samples have been accepted since reset
//   overrun      sticky flag; a trigger was dropped by the start-gap rule
module mca_s_window_buffer #(
  parameter int K             = 256,
  parameter int N             = 8,
  parameter int DSR           = 4,
  parameter int MIN_START_GAP = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [N-1:0]        s_in,
  input  logic                s_valid,
  input  logic                overrun_clr,
  output logic [K-1:0][N-1:0] S_matrix,
  output logic                start,
  output logic                primed,
  output logic                overrun
);

  localparam int FW = $clog2(K + 1);
  localparam int DW = (DSR > 1) ? $clog2(DSR) : 1;
  localparam int GW = $clog2(MIN_START_GAP + 1);

  localparam logic [FW-1:0] FILL_MAX = FW'(K);
  localparam logic [FW-1:0] FILL_PRE = FW'(K - 1);
  localparam logic [DW-1:0] DEC_MAX  = DW'(DSR - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(MIN_START_GAP);

  // The WARMUP/RUN state is visible on the primed output.
  typedef enum logic {WARMUP = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [K-1:0][N-1:0] lb_q, lb_d;
  logic [FW-1:0]       fill_q;
  logic [DW-1:0]       dec_q;
  logic [GW-1:0]       gap_q;      // cycles since the last start, saturating
  logic                seen_start_q;
  logic                trigger, gap_ok, grant, drop;

  // Post-shift contents. The window loads this value, so a granted trigger
  // captures its own sample in entry 0.
  always_comb begin
    lb_d = lb_q;
    if (s_valid) lb_d = {lb_q[K-2:0], s_in};
  end

  // The trigger needs the fill count to reach K including the current
  // sample. That is true when the count is already K, or K-1 before this
  // sample.
  always_comb begin
    state_d = state_q;
    trigger = s_valid && (dec_q == DEC_MAX) &&
              ((fill_q == FILL_MAX) || (fill_q == FILL_PRE));
    gap_ok  = !seen_start_q || (gap_q >= GAP_MAX);
    grant   = trigger && gap_ok;
    drop    = trigger && !gap_ok;
    case (state_q)
      WARMUP:  if (s_valid && (fill_q == FILL_PRE)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = WARMUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= WARMUP;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lb_q         <= '0;
      S_matrix     <= '0;
      fill_q       <= '0;
      dec_q        <= '0;
      gap_q        <= '0;
      seen_start_q <= 1'b0;
      start        <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      lb_q  <= lb_d;
      start <= grant;

      if (s_valid) begin
        if (fill_q != FILL_MAX) fill_q <= fill_q + FW'(1);
        dec_q <= (dec_q == DEC_MAX) ? '0 : dec_q + DW'(1);
      end

      // gap_q is set to 1 on the edge that raises start. A trigger exactly
      // MIN_START_GAP edges after that one therefore sees gap_q == GAP_MAX.
      if (grant) begin
        S_matrix     <= lb_d;
        seen_start_q <= 1'b1;
        gap_q        <= GW'(1);
      end else if (gap_q < GAP_MAX) begin
        gap_q <= gap_q + GW'(1);
      end

      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  assign primed = (state_q == RUN);

endmodule
